// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and register-map constants for the UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [1:0] UART_TXDATA_OFS = 2'd0;
    localparam logic [1:0] UART_STATUS_OFS = 2'd1;

    localparam int ST_BUSY = 0;
    localparam int ST_OVR  = 1;

    // Word offset within the 16-byte peripheral window.
    function automatic logic [1:0] reg_ofs(input logic [3:0] byte_addr);
        return byte_addr[3:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period counter; pulses tick on the last cycle of each bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Held at zero while disabled so every frame starts on a full bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == TERM);

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped 8N1 UART transmitter with TXDATA/STATUS registers.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [3:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              tx,
    output logic              busy
);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        ovr_q, ovr_d;
    logic        tx_q, tx_d;

    logic        tick;
    logic [1:0]  ofs;
    logic        wr;
    logic        wr_tx;
    logic        wr_st;
    logic        frame_end;
    logic        accept;
    logic        unused_bits;

    assign ofs       = reg_ofs(addr);
    assign wr        = sel & MemWrite;
    assign wr_tx     = wr && (ofs == UART_TXDATA_OFS);
    assign wr_st     = wr && (ofs == UART_STATUS_OFS);
    assign frame_end = (state_q == STOP) && tick;
    // A write landing on the frame's final edge starts the next frame with no gap.
    assign accept    = wr_tx && ((state_q == IDLE) || frame_end);
    assign busy      = (state_q != IDLE);
    assign unused_bits = ^{addr[1:0], wdata[DATA_W-1:8]};

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        ovr_d     = ovr_q;
        tx_d      = 1'b1;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d   = START;
            shift_d   = wdata[7:0];
            bit_idx_d = 3'd0;
        end

        if (wr_st && wdata[ST_OVR]) begin
            ovr_d = 1'b0;
        end
        if (wr_tx && !accept) begin
            ovr_d = 1'b1;
        end

        // tx is computed from next state so the line register changes on the same edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            ovr_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            ovr_q     <= ovr_d;
            tx_q      <= tx_d;
        end
    end

    assign tx = tx_q;

    always_comb begin
        rdata = '0;
        if (sel && MemRead && (ofs == UART_STATUS_OFS)) begin
            rdata[ST_BUSY] = busy;
            rdata[ST_OVR]  = ovr_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_mmio
// Description : Self-checking bench for uart_tx_mmio at 4 and 2 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        MemWrite;
    logic        MemRead;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        tx_a, tx_b, busy_a, busy_b;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    uart_tx_mmio #(.CLKS_PER_BIT(4), .DATA_W(32)) dut_a (
        .clk(clk), .rst(rst), .sel(sel), .MemWrite(MemWrite), .MemRead(MemRead),
        .addr(addr), .wdata(wdata), .rdata(rdata_a), .tx(tx_a), .busy(busy_a)
    );

    uart_tx_mmio #(.CLKS_PER_BIT(2), .DATA_W(32)) dut_b (
        .clk(clk), .rst(rst), .sel(sel), .MemWrite(MemWrite), .MemRead(MemRead),
        .addr(addr), .wdata(wdata), .rdata(rdata_b), .tx(tx_b), .busy(busy_b)
    );

    // Frame-level model: a frame is a 10-bit word replayed one bit per N cycles.
    bit         m_active[2];
    int         m_cnt[2];
    logic [9:0] m_frame[2];
    bit         m_ovr[2];

    function automatic int nb(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_active[d] = 1'b0;
                m_cnt[d]    = 0;
                m_ovr[d]    = 1'b0;
            end else begin
                if (m_active[d]) begin
                    m_cnt[d] = m_cnt[d] + 1;
                    if (m_cnt[d] == 10 * nb(d)) m_active[d] = 1'b0;
                end
                if (sel && MemWrite && addr[3:2] == 2'd1 && wdata[1]) m_ovr[d] = 1'b0;
                if (sel && MemWrite && addr[3:2] == 2'd0) begin
                    if (!m_active[d]) begin
                        m_active[d] = 1'b1;
                        m_cnt[d]    = 0;
                        m_frame[d]  = {1'b1, wdata[7:0], 1'b0};
                    end else begin
                        m_ovr[d] = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic exp_tx(input int d);
        if (!m_active[d]) return 1'b1;
        return m_frame[d][m_cnt[d] / nb(d)];
    endfunction

    function automatic logic [31:0] exp_rdata(input int d);
        if (sel && MemRead && addr[3:2] == 2'd1) return {30'd0, m_ovr[d], m_active[d]};
        return 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 1'b0; m_cnt[d] = 0; m_frame[d] = '1; m_ovr[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            model_edge();
            #1;
            if (chk_en) begin
                check("tx_n4",    {31'd0, tx_a},   {31'd0, exp_tx(0)});
                check("busy_n4",  {31'd0, busy_a}, {31'd0, m_active[0]});
                check("rdata_n4", rdata_a,         exp_rdata(0));
                check("tx_n2",    {31'd0, tx_b},   {31'd0, exp_tx(1)});
                check("busy_n2",  {31'd0, busy_b}, {31'd0, m_active[1]});
                check("rdata_n2", rdata_b,         exp_rdata(1));
            end
        end
    end

    // Caller sits just after a falling edge; the write lands on the next rising edge.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic s);
        sel = s; MemWrite = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; MemWrite = 1'b0; addr = 4'd0; wdata = 32'd0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] va, output logic [31:0] vb);
        sel = 1'b1; MemRead = 1'b1; addr = a;
        #1;
        va = rdata_a; vb = rdata_b;
        sel = 1'b0; MemRead = 1'b0; addr = 4'd0;
    endtask

    int          seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic [31:0] va, vb;

    initial begin
        rst = 1'b1; sel = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; addr = 4'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        check("reset_tx", {31'd0, tx_a}, 32'd1);
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            read_reg(4'h4, va, vb);
            check("idle_status", va, 32'd0);
            @(negedge clk);
        end

        // 0xA5 frame against a hand-written bit sequence
        do_write(4'h0, 32'hA5, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("a5_bit", {31'd0, tx_a}, seq[i]);
            check("a5_busy", {31'd0, busy_a}, 32'd1);
            repeat (4) @(negedge clk);
        end
        check("a5_busy_fall", {31'd0, busy_a}, 32'd0);

        // Overrun during a frame, then clear
        do_write(4'h0, 32'h3C, 1'b1);
        repeat (9) @(negedge clk);
        do_write(4'h0, 32'h99, 1'b1);
        read_reg(4'h4, va, vb);
        check("ovr_status_busy", va, 32'h3);
        repeat (31) @(negedge clk);
        read_reg(4'h4, va, vb);
        check("ovr_status_after", va, 32'h2);
        do_write(4'h4, 32'h2, 1'b1);
        read_reg(4'h4, va, vb);
        check("ovr_cleared", va, 32'h0);
        repeat (2) @(negedge clk);

        // Reset mid-frame, then a fresh frame
        do_write(4'h0, 32'h55, 1'b1);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx", {31'd0, tx_a}, 32'd1);
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        repeat (2) @(negedge clk);
        do_write(4'h0, 32'h0F, 1'b1);
        check("restart_tx", {31'd0, tx_a}, 32'd0);
        check("restart_busy", {31'd0, busy_a}, 32'd1);
        repeat (45) @(negedge clk);

        // Writes that must be ignored
        do_write(4'h0, 32'h5A, 1'b0);
        do_write(4'h8, 32'h5A, 1'b1);
        check("ign_busy", {31'd0, busy_a}, 32'd0);
        check("ign_tx", {31'd0, tx_a}, 32'd1);
        read_reg(4'h8, va, vb);
        check("read_8", va, 32'd0);
        read_reg(4'h0, va, vb);
        check("read_txdata", va, 32'd0);
        read_reg(4'h4, va, vb);
        check("ign_status", va, 32'd0);

        // Back-to-back frames, N=4
        do_write(4'h0, 32'hFF, 1'b1);
        repeat (39) @(negedge clk);
        do_write(4'h0, 32'h01, 1'b1);
        check("b2b4_busy", {31'd0, busy_a}, 32'd1);
        check("b2b4_tx", {31'd0, tx_a}, 32'd0);
        read_reg(4'h4, va, vb);
        check("b2b4_status", va, 32'h1);
        repeat (45) @(negedge clk);

        // Back-to-back frames, N=2 (the N=4 instance overruns here)
        do_write(4'h0, 32'hFF, 1'b1);
        repeat (19) @(negedge clk);
        do_write(4'h0, 32'h01, 1'b1);
        check("b2b2_busy", {31'd0, busy_b}, 32'd1);
        check("b2b2_tx", {31'd0, tx_b}, 32'd0);
        read_reg(4'h4, va, vb);
        check("b2b2_status", vb, 32'h1);
        check("b2b2_other", va, 32'h3);
        do_write(4'h4, 32'h2, 1'b1);
        repeat (45) @(negedge clk);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 699) == 0);
            sel      = ($urandom_range(0, 3) != 0);
            MemWrite = ($urandom_range(0, 24) == 0);
            MemRead  = $urandom_range(0, 1) == 1;
            addr     = 4'($urandom_range(0, 15));
            wdata    = $urandom;
            @(negedge clk);
        end
        rst = 1'b0; sel = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; addr = 4'd0; wdata = 32'd0;
        repeat (50) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
